fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Sequencer and scheduler for a time-multiplexed FIR filter: one shared signed multiplier and an accumulator are reused across all taps instead of one multiplier per tap. The block loads the coefficients, buffers sample history, and steps the multiply-accumulate over all taps. It delivers one saturated output per accepted sample over a valid/ready handshake. It sits between the pin-level sample input and the output pins of the FIR top level.

## Interface
- N_TAPS, 5, number of taps (2..15)
- BW_in, 6, two's-complement width of samples and coefficients
- BW_out, 8, two's-complement output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- cfg_reload  in  1  request to reload coefficients (pulse)
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  BW_in  coefficient (LOAD state) or sample (IDLE state), signed
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  BW_out  filtered sample, signed, saturated
- busy  out  1  high in MAC and OUT states

## Operation
- States: LOAD, IDLE, MAC, OUT. Reset enters LOAD with load index 0. Reset clears all coefficients, sample history, the accumulator and out_data to 0.
- LOAD: in_ready=1. On each in_valid&in_ready, store in_data as coeff[idx] and increment idx. The first coefficient loaded is coeff[0], which is applied to the newest sample. After coeff[N_TAPS-1] is stored, go to IDLE. A cfg_reload in LOAD restarts idx at 0; coefficients already stored are kept until overwritten.
- IDLE: in_ready=1.
  - On a handshake, the sample is written into the circular history at the write pointer. The write pointer advances modulo N_TAPS, wrapping from N_TAPS-1 to 0. The accumulator clears, tap counter k=0, and the state goes to MAC.
  - cfg_reload in IDLE without a handshake: clear the history and the write pointer, set idx=0, go to LOAD.
  - cfg_reload together with a handshake: the handshake wins and cfg_reload is dropped.
- MAC: in_ready=0. Each cycle, acc += coeff[k] * x[n-k] (full-precision signed product, width 2*BW_in). k increments each cycle. History slots never written since reset or reload read as 0.
  - Accumulator width: 2*BW_in + ceil(log2(N_TAPS)), so it never overflows.
  - After k=N_TAPS-1, out_data = sat(acc >>> SHIFT) to [-2^(BW_out-1), 2^(BW_out-1)-1]. The state goes to OUT.
- OUT: in_ready=0, out_valid=1. out_data stays stable until out_valid&out_ready, then the state goes to IDLE. cfg_reload is ignored in MAC and OUT.
- out_data holds its last value while out_valid=0.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1 in the cycle after reset deasserts (LOAD). out_valid=0, out_data=0, busy=0.
- Sample handshake at edge T: MAC occupies cycles T+1..T+N_TAPS, and out_valid=1 from cycle T+N_TAPS+1.
- Latency is N_TAPS+1 cycles from the accept edge to out_valid.
- With out_ready held high, the minimum sample interval is N_TAPS+2 cycles. in_ready rises in the cycle after the output handshake.
- Coefficient load takes N_TAPS handshakes at up to 1 per cycle. in_ready is first asserted in IDLE in the cycle after the last coefficient handshake.
- Reset asserted in any state, including mid-MAC or OUT, wins over all other inputs: the next cycle is LOAD with all registers cleared and out_valid=0.
- Combinational paths: in_ready and out_valid are derived from the state register only; no input-to-output combinational path.

## Test plan
- Impulse response: load coeffs 1,2,3,4,5, then send samples 1,0,0,0,0,0 with out_ready=1 -> out_data sequence 1,2,3,4,5,0. Each output appears 6 cycles after its accept edge.
- Saturation:
  - Coeffs all 31, samples 31 repeated -> 5th and later outputs = 127 (acc 4805).
  - Coeffs all -32, samples 31 -> 5th and later outputs = -128 (acc -4960).
  - Coeffs 1,0,0,0,0 with sample -3 -> -3.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid stays 1, out_data stable, in_ready=0. A later out_ready=1 produces exactly one handshake and in_ready=1 on the next cycle.
- Reload: after outputs flow, pulse cfg_reload in IDLE, load coeffs 0,0,0,0,1, send 7,0,0,0,0 -> outputs 0,0,0,0,7; the history was cleared, so no residue from old samples.
- cfg_reload during MAC and OUT -> ignored; the output matches a run without the pulse. cfg_reload coincident with an IDLE handshake -> the sample is processed and the block stays out of LOAD.
- Reset mid-MAC (2 cycles into MAC) -> next cycle out_valid=0, out_data=0, state LOAD with in_ready=1. The first output after reload matches the result from a fresh power-on.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR sequencer. One shared signed
// multiplier and one accumulator step through all taps for every accepted
// sample; coefficients are loaded serially over the same input port.
module fir_mac_sequencer #(
    parameter int N_TAPS = 5,
    parameter int BW_in  = 6,
    parameter int BW_out = 8,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_reload,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [BW_in-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [BW_out-1:0] out_data,
    output logic                     busy
);

    localparam int IDX_W  = $clog2(N_TAPS);
    localparam int PROD_W = 2 * BW_in;
    localparam int ACC_W  = 2 * BW_in + $clog2(N_TAPS);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_TAPS - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (BW_out - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (BW_out - 1)));

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_MAC  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         k_q, k_d;
    logic [IDX_W-1:0]         wptr_q, wptr_d;
    logic [IDX_W-1:0]         rptr_q, rptr_d;
    logic signed [BW_in-1:0]  coeff_q [N_TAPS];
    logic signed [BW_in-1:0]  coeff_d [N_TAPS];
    logic signed [BW_in-1:0]  hist_q  [N_TAPS];
    logic signed [BW_in-1:0]  hist_d  [N_TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [BW_out-1:0] out_data_q, out_data_d;

    logic                     in_hs;
    logic                     out_hs;
    logic signed [BW_in-1:0]  coeff_sel;
    logic signed [BW_in-1:0]  hist_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_shift;

    // Handshake and status outputs depend only on the state register.
    assign in_ready  = (state_q == ST_LOAD) || (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q == ST_MAC) || (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Shared datapath: one full-precision product per cycle, added to the accumulator.
    always_comb begin
        coeff_sel = coeff_q[k_q];
        hist_sel  = hist_q[rptr_q];
        prod      = PROD_W'(coeff_sel) * PROD_W'(hist_sel);
        acc_sum   = acc_q + ACC_W'(prod);
        acc_shift = acc_sum >>> SHIFT;
    end

    // Next-state logic for the load / idle / multiply-accumulate / output sequence.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        k_d        = k_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        coeff_d    = coeff_q;
        hist_d     = hist_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;

        case (state_q)
            ST_LOAD: begin
                if (in_hs && cfg_reload) begin
                    coeff_d[0] = in_data;
                    idx_d      = IDX_W'(1);
                end else if (in_hs) begin
                    coeff_d[idx_q] = in_data;
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (cfg_reload) begin
                    idx_d = '0;
                end
            end
            ST_IDLE: begin
                if (in_hs) begin
                    hist_d[wptr_q] = in_data;
                    rptr_d         = wptr_q;
                    wptr_d         = (wptr_q == LAST) ? '0 : wptr_q + IDX_W'(1);
                    acc_d          = '0;
                    k_d            = '0;
                    state_d        = ST_MAC;
                end else if (cfg_reload) begin
                    for (int i = 0; i < N_TAPS; i++) begin
                        hist_d[i] = '0;
                    end
                    wptr_d  = '0;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_MAC: begin
                acc_d  = acc_sum;
                rptr_d = (rptr_q == '0) ? LAST : rptr_q - IDX_W'(1);
                if (k_q == LAST) begin
                    if (acc_shift > SAT_MAX) begin
                        out_data_d = BW_out'(SAT_MAX);
                    end else if (acc_shift < SAT_MIN) begin
                        out_data_d = BW_out'(SAT_MIN);
                    end else begin
                        out_data_d = BW_out'(acc_shift);
                    end
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            default: begin
                if (out_hs) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous reset clearing every register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            idx_q      <= '0;
            k_q        <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            coeff_q    <= '{default: '0};
            hist_q     <= '{default: '0};
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            coeff_q    <= coeff_d;
            hist_q     <= hist_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed vectors for the FIR MAC sequencer. Expected
// outputs are queued when a sample is sent; a negedge monitor pops and
// compares on every output handshake.
module tb_fir_mac_sequencer;

    localparam int N_TAPS = 5;
    localparam int BW_in  = 6;
    localparam int BW_out = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     cfg_reload;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [BW_in-1:0]  in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [BW_out-1:0] out_data;
    logic                     busy;

    int checks  = 0;
    int errors  = 0;
    int out_idx = 0;
    int exp_q[$];

    fir_mac_sequencer #(
        .N_TAPS(N_TAPS),
        .BW_in (BW_in),
        .BW_out(BW_out),
        .SHIFT (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_reload(cfg_reload),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: compare every output handshake against the queue head.
    always @(negedge clk) begin : monitor
        int e;
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected output #%0d: actual %0d, required none", out_idx, out_data);
            end else begin
                e = exp_q.pop_front();
                check_val($sformatf("out_data[%0d]", out_idx), 32'(out_data), e);
            end
            out_idx++;
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready timeout: actual 0, required 1");
        end
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_valid timeout: actual 0, required 1");
        end
    endtask

    task automatic apply_stimulus(input int s, input int e, input bit rel = 1'b0);
        wait_ready();
        exp_q.push_back(e);
        in_valid   = 1'b1;
        in_data    = BW_in'(s);
        cfg_reload = rel;
        tick();
        in_valid   = 1'b0;
        cfg_reload = 1'b0;
    endtask

    task automatic load_coeffs(input int c0, input int c1, input int c2, input int c3, input int c4);
        int c [N_TAPS];
        c = '{c0, c1, c2, c3, c4};
        for (int i = 0; i < N_TAPS; i++) begin
            wait_ready();
            in_valid = 1'b1;
            in_data  = BW_in'(c[i]);
            tick();
        end
        in_valid = 1'b0;
        check_val("in_ready after load", 32'(in_ready), 1);
        check_val("busy after load", 32'(busy), 0);
    endtask

    task automatic reload_pulse();
        wait_ready();
        cfg_reload = 1'b1;
        tick();
        cfg_reload = 1'b0;
    endtask

    task automatic check_output_drained(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check_val(name, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        cfg_reload = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;

        // Power-on reset
        tick();
        tick();
        check_val("reset out_valid", 32'(out_valid), 0);
        check_val("reset out_data", 32'(out_data), 0);
        check_val("reset busy", 32'(busy), 0);
        reset = 1'b0;
        tick();
        check_val("post-reset in_ready", 32'(in_ready), 1);
        check_val("post-reset busy", 32'(busy), 0);

        // Impulse response with latency check on the first sample
        load_coeffs(1, 2, 3, 4, 5);
        apply_stimulus(1, 1);
        for (int i = 1; i <= N_TAPS; i++) begin
            check_val($sformatf("latency out_valid low c%0d", i), 32'(out_valid), 0);
            check_val($sformatf("latency busy c%0d", i), 32'(busy), 1);
            tick();
        end
        check_val("latency out_valid high", 32'(out_valid), 1);
        apply_stimulus(0, 2);
        apply_stimulus(0, 3);
        apply_stimulus(0, 4);
        apply_stimulus(0, 5);
        apply_stimulus(0, 0);
        check_output_drained("impulse drained");

        // Positive saturation: 961*m all above 127
        reload_pulse();
        load_coeffs(31, 31, 31, 31, 31);
        for (int i = 0; i < 5; i++) apply_stimulus(31, 127);
        check_output_drained("sat+ drained");

        // Negative saturation: -992*m all below -128
        reload_pulse();
        load_coeffs(-32, -32, -32, -32, -32);
        for (int i = 0; i < 5; i++) apply_stimulus(31, -128);
        check_output_drained("sat- drained");

        // Near-boundary values that must not saturate
        reload_pulse();
        load_coeffs(4, 0, 0, 0, 0);
        apply_stimulus(31, 124);
        apply_stimulus(-32, -128);
        apply_stimulus(26, 104);
        check_output_drained("boundary drained");

        reload_pulse();
        load_coeffs(1, 0, 0, 0, 0);
        apply_stimulus(-3, -3);
        check_output_drained("negative drained");

        // Backpressure: output held for 10 cycles
        out_ready = 1'b0;
        apply_stimulus(9, 9);
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("bp out_valid c%0d", i), 32'(out_valid), 1);
            check_val($sformatf("bp out_data c%0d", i), 32'(out_data), 9);
            check_val($sformatf("bp in_ready c%0d", i), 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_val("bp in_ready after handshake", 32'(in_ready), 1);
        check_val("bp out_valid after handshake", 32'(out_valid), 0);
        check_val("bp out_data held", 32'(out_data), 9);
        check_val("bp single handshake", exp_q.size(), 0);
        tick();
        check_val("bp out_valid stays low", 32'(out_valid), 0);

        // cfg_reload ignored in MAC and OUT
        out_ready = 1'b0;
        apply_stimulus(2, 2);
        tick();
        check_val("mac busy", 32'(busy), 1);
        cfg_reload = 1'b1;
        tick();
        cfg_reload = 1'b0;
        wait_out_valid();
        cfg_reload = 1'b1;
        tick();
        cfg_reload = 1'b0;
        check_val("out ignores reload", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        apply_stimulus(6, 6);
        // cfg_reload coincident with an IDLE handshake: sample wins
        apply_stimulus(7, 7, 1'b1);
        apply_stimulus(8, 8);
        check_output_drained("reload-ignored drained");

        // Reload clears the history
        reload_pulse();
        load_coeffs(0, 0, 0, 0, 1);
        apply_stimulus(7, 0);
        apply_stimulus(0, 0);
        apply_stimulus(0, 0);
        apply_stimulus(0, 0);
        apply_stimulus(0, 7);
        check_output_drained("reload drained");

        // Reset two cycles into MAC
        wait_ready();
        in_valid = 1'b1;
        in_data  = BW_in'(3);
        tick();
        in_valid = 1'b0;
        tick();
        check_val("pre-reset busy", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid-MAC reset out_valid", 32'(out_valid), 0);
        check_val("mid-MAC reset out_data", 32'(out_data), 0);
        check_val("mid-MAC reset in_ready", 32'(in_ready), 1);
        check_val("mid-MAC reset busy", 32'(busy), 0);
        load_coeffs(1, 2, 3, 4, 5);
        apply_stimulus(1, 1);
        apply_stimulus(0, 2);
        apply_stimulus(0, 3);
        apply_stimulus(0, 4);
        apply_stimulus(0, 5);
        apply_stimulus(0, 0);
        check_output_drained("post-reset drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
